// File: rtl/vend_pkg.sv
// Shared definitions for the coin vending controller: coin codes, coin
// valuation in 5-rupee units and the controller state encoding.
package vend_pkg;

  localparam logic [1:0] COIN_5   = 2'd0;
  localparam logic [1:0] COIN_10  = 2'd1;
  localparam logic [1:0] COIN_20  = 2'd2;
  localparam logic [1:0] COIN_BAD = 2'd3;

  typedef enum logic {COLLECT, CHANGE} state_t;

  function automatic logic [2:0] coin_units(input logic [1:0] coin);
    case (coin)
      COIN_5:  coin_units = 3'd1;
      COIN_10: coin_units = 3'd2;
      COIN_20: coin_units = 3'd4;
      default: coin_units = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vending_controller.sv
// Coin-accepting vending controller: credits coins in 5-rupee units, vends at
// PRICE_UNITS and pays surplus or cancelled credit back one coin per handshake.
module vending_controller
  import vend_pkg::*;
#(
  parameter int PRICE_UNITS = 3,
  parameter int MAX_UNITS   = 8,
  parameter int CREDIT_W    = 4,
  parameter int COUNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                cancel,
  input  logic                chg_ready,
  output logic                vend,
  output logic                coin_reject,
  output logic                chg_valid,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic [COUNT_W-1:0]  vend_count
);

  if (PRICE_UNITS > MAX_UNITS || MAX_UNITS >= 2**CREDIT_W) begin : g_param_check
    $error("vending_controller: need PRICE_UNITS <= MAX_UNITS < 2**CREDIT_W");
  end

  localparam logic [CREDIT_W:0] PRICE_L = (CREDIT_W+1)'(PRICE_UNITS);
  localparam logic [CREDIT_W:0] MAX_L   = (CREDIT_W+1)'(MAX_UNITS);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic                vend_q, vend_d;
  logic                reject_q, reject_d;
  logic [CREDIT_W:0]   sum;

  // One extra bit so an over-limit sum is visible rather than wrapping.
  assign sum = {1'b0, credit_q} + (CREDIT_W+1)'(coin_units(coin_type));

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    count_d  = count_q;
    vend_d   = 1'b0;
    reject_d = 1'b0;
    case (state_q)
      COLLECT: begin
        if (cancel) begin
          reject_d = coin_valid;
          if (credit_q != '0) state_d = CHANGE;
        end else if (coin_valid) begin
          if (coin_type == COIN_BAD || sum > MAX_L) begin
            reject_d = 1'b1;
          end else if (sum >= PRICE_L) begin
            vend_d   = 1'b1;
            count_d  = count_q + COUNT_W'(1);
            credit_d = CREDIT_W'(sum - PRICE_L);
            if (sum != PRICE_L) state_d = CHANGE;
          end else begin
            credit_d = CREDIT_W'(sum);
          end
        end
      end
      CHANGE: begin
        reject_d = coin_valid;
        if (chg_ready) begin
          credit_d = credit_q - CREDIT_W'(1);
          if (credit_q == CREDIT_W'(1)) state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= COLLECT;
      credit_q <= '0;
      count_q  <= '0;
      vend_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      count_q  <= count_d;
      vend_q   <= vend_d;
      reject_q <= reject_d;
    end
  end

  assign vend        = vend_q;
  assign coin_reject = reject_q;
  assign credit      = credit_q;
  assign vend_count  = count_q;
  assign chg_valid   = (state_q == CHANGE);
  assign busy        = (state_q == CHANGE);

endmodule

// File: tb/tb_vending_controller.sv
// Bench for vending_controller: three configurations driven in lockstep and
// compared every cycle against a credit-ledger reference model.
module tb_vending_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_type = 2'd0;
  logic       cancel = 1'b0;
  logic       chg_ready = 1'b0;

  logic        vend0, rej0, chgv0, busy0;
  logic [3:0]  cred0;
  logic [15:0] cnt0;
  logic        vend1, rej1, chgv1, busy1;
  logic [3:0]  cred1;
  logic [15:0] cnt1;
  logic        vend2, rej2, chgv2, busy2;
  logic [3:0]  cred2;
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vending_controller u0 (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_type(coin_type),
    .cancel(cancel), .chg_ready(chg_ready), .vend(vend0), .coin_reject(rej0),
    .chg_valid(chgv0), .credit(cred0), .busy(busy0), .vend_count(cnt0));

  vending_controller #(.PRICE_UNITS(8), .MAX_UNITS(10)) u1 (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_type(coin_type),
    .cancel(cancel), .chg_ready(chg_ready), .vend(vend1), .coin_reject(rej1),
    .chg_valid(chgv1), .credit(cred1), .busy(busy1), .vend_count(cnt1));

  vending_controller #(.COUNT_W(2)) u2 (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_type(coin_type),
    .cancel(cancel), .chg_ready(chg_ready), .vend(vend2), .coin_reject(rej2),
    .chg_valid(chgv2), .credit(cred2), .busy(busy2), .vend_count(cnt2));

  // Reference ledger per instance: credit held, whether coins are owed back,
  // vends so far, and the last cycle's pulses.
  int price [3] = '{3, 8, 3};
  int maxu  [3] = '{8, 10, 8};
  int cmod  [3] = '{65536, 65536, 4};
  int value [4] = '{1, 2, 4, 0};
  int m_credit [3];
  bit m_owing  [3];
  int m_vends  [3];
  bit m_vend   [3];
  bit m_rej    [3];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int i);
    int s;
    m_vend[i] = 1'b0;
    m_rej[i]  = 1'b0;
    if (reset) begin
      m_credit[i] = 0;
      m_owing[i]  = 1'b0;
      m_vends[i]  = 0;
    end else if (m_owing[i]) begin
      m_rej[i] = coin_valid;
      if (chg_ready) begin
        m_credit[i]--;
        if (m_credit[i] == 0) m_owing[i] = 1'b0;
      end
    end else if (cancel) begin
      m_rej[i] = coin_valid;
      if (m_credit[i] > 0) m_owing[i] = 1'b1;
    end else if (coin_valid) begin
      s = m_credit[i] + value[coin_type];
      if (coin_type == 2'd3 || s > maxu[i]) begin
        m_rej[i] = 1'b1;
      end else if (s >= price[i]) begin
        m_vend[i]   = 1'b1;
        m_vends[i]  = (m_vends[i] + 1) % cmod[i];
        m_credit[i] = s - price[i];
        m_owing[i]  = (m_credit[i] > 0);
      end else begin
        m_credit[i] = s;
      end
    end
  endtask

  task automatic compare(input int i, input bit v, input bit r, input bit cv,
                         input bit b, input int c, input int n);
    check($sformatf("u%0d.vend", i), v, m_vend[i]);
    check($sformatf("u%0d.coin_reject", i), r, m_rej[i]);
    check($sformatf("u%0d.chg_valid", i), cv, m_owing[i]);
    check($sformatf("u%0d.busy", i), b, m_owing[i]);
    check($sformatf("u%0d.credit", i), c, m_credit[i]);
    check($sformatf("u%0d.vend_count", i), n, m_vends[i]);
  endtask

  task automatic cyc(input bit rst, input bit cv, input logic [1:0] ct,
                     input bit cn, input bit rdy);
    reset = rst; coin_valid = cv; coin_type = ct; cancel = cn; chg_ready = rdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) model_step(i);
    compare(0, vend0, rej0, chgv0, busy0, cred0, cnt0);
    compare(1, vend1, rej1, chgv1, busy1, cred1, cnt1);
    compare(2, vend2, rej2, chgv2, busy2, cred2, cnt2);
    check("u0.vend_and_reject", int'(vend0 & rej0), 0);
  endtask

  task automatic coin(input logic [1:0] ct, input bit rdy);
    cyc(1'b0, 1'b1, ct, 1'b0, rdy);
  endtask

  task automatic idle(input bit rdy);
    cyc(1'b0, 1'b0, 2'd0, 1'b0, rdy);
  endtask

  initial begin
    // Reset state
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    check("rst.credit", cred0, 0);
    check("rst.chg_valid", chgv0, 0);
    check("rst.vend_count", cnt0, 0);

    // 5 then 10: exact price
    coin(2'd0, 1'b0);
    coin(2'd1, 1'b0);
    check("exact.vend", vend0, 1);
    check("exact.credit", cred0, 0);
    idle(1'b0);
    check("exact.vend_pulse", vend0, 0);
    check("exact.chg_valid", chgv0, 0);
    check("exact.vend_count", cnt0, 1);

    // 10, 10 with ready: one coin of change
    coin(2'd1, 1'b1);
    coin(2'd1, 1'b1);
    check("surplus.vend", vend0, 1);
    check("surplus.credit", cred0, 1);
    check("surplus.chg_valid", chgv0, 1);
    idle(1'b1);
    check("surplus.chg_drop", chgv0, 0);
    check("surplus.credit0", cred0, 0);

    // 20 with actuator stalled, coin during wait rejected
    coin(2'd2, 1'b0);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) coin(2'd0, 1'b0);
      else idle(1'b0);
      check("stall.chg_valid", chgv0, 1);
      check("stall.credit", cred0, 1);
    end
    idle(1'b1);
    check("stall.release", cred0, 0);

    // Cancel with simultaneous coin, then bad coin
    coin(2'd0, 1'b0);
    coin(2'd0, 1'b0);
    cyc(1'b0, 1'b1, 2'd1, 1'b1, 1'b0);
    check("cancel.reject", rej0, 1);
    check("cancel.credit", cred0, 2);
    idle(1'b1);
    idle(1'b1);
    check("cancel.refunded", cred0, 0);
    coin(2'd3, 1'b1);
    check("bad.reject", rej0, 1);

    // High-price configuration: over-limit rejection
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    coin(2'd1, 1'b1);
    coin(2'd1, 1'b1);
    coin(2'd1, 1'b1);
    coin(2'd0, 1'b1);
    check("hi.credit7", cred1, 7);
    coin(2'd2, 1'b1);
    check("hi.over_reject", rej1, 1);
    check("hi.credit_kept", cred1, 7);
    coin(2'd0, 1'b1);
    check("hi.vend", vend1, 1);
    check("hi.credit0", cred1, 0);

    // Reset during change with credit 3
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    coin(2'd0, 1'b0);
    coin(2'd0, 1'b0);
    coin(2'd2, 1'b0);
    check("rstchg.credit3", cred0, 3);
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    check("rstchg.credit", cred0, 0);
    check("rstchg.chg_valid", chgv0, 0);
    check("rstchg.busy", busy0, 0);
    check("rstchg.vend", vend0, 0);

    // Counter wrap on the 2-bit instance
    for (int k = 0; k < 5; k++) begin
      coin(2'd0, 1'b1);
      coin(2'd1, 1'b1);
    end
    check("wrap.count", cnt2, 1);
    check("wrap.count_wide", cnt0, 5);

    // Randomized traffic against the ledger
    for (int k = 0; k < 2000; k++) begin
      cyc(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
